// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite responder backed by a byte-wide local memory (single-beat reads/writes).
// Optional AXI_LITE_ADDR_CHECK_EN: flag addresses above the memory range with DECERR instead of aliasing.
package axi_lite_pkg;
    parameter int ADDR_WIDTH  = 32;
    parameter int DATA_WIDTH  = 8;
    parameter int BUFFER_SIZE = 4096;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_type;
endpackage

// state | meaning
// IDLE  | no transaction; reads win over writes
// RADDR | arready high, araddr captured, read data/response registered
// RDATA | rvalid high until rready
// WADDR | awready high, awaddr captured
// WDATA | wready high until wvalid, memory written on the handshake
// WRESP | bvalid high until bready
module axi_lite_mem_responder
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = axi_lite_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = axi_lite_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH  = axi_lite_pkg::BUFFER_SIZE,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    state_type state, state_next;

    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic                  rd_in_range;
    logic                  wr_in_range;
    logic                  wr_commit;

    assign rd_idx = araddr[IDX_W-1:0];
    assign wr_idx = waddr_q[IDX_W-1:0];

`ifdef AXI_LITE_ADDR_CHECK_EN
    assign rd_in_range = (araddr[ADDR_WIDTH-1:IDX_W] == '0);
    assign wr_in_range = (waddr_q[ADDR_WIDTH-1:IDX_W] == '0);
`else
    // Upper address bits alias onto the memory, so they play no part.
    logic unused_upper_addr;
    assign unused_upper_addr = ^{araddr[ADDR_WIDTH-1:IDX_W], waddr_q[ADDR_WIDTH-1:IDX_W]};
    assign rd_in_range = 1'b1;
    assign wr_in_range = 1'b1;
`endif

    assign wr_commit = (state == WDATA) && wvalid && wr_in_range && wstrb[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        arready    = 1'b0;
        rvalid     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        case (state)
            IDLE: begin
                if (arvalid) begin
                    state_next = RADDR;
                end else if (awvalid) begin
                    state_next = WADDR;
                end
            end
            RADDR: begin
                arready    = 1'b1;
                state_next = RDATA;
            end
            RDATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    state_next = IDLE;
                end
            end
            WADDR: begin
                awready    = 1'b1;
                state_next = WDATA;
            end
            WDATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    state_next = WRESP;
                end
            end
            WRESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read data and both responses are registered so they stay put while the master stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_q <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            bresp   <= RESP_OKAY;
        end else begin
            case (state)
                RADDR: begin
                    rdata <= rd_in_range ? mem[rd_idx] : '0;
                    rresp <= rd_in_range ? RESP_OKAY : RESP_DECERR;
                end
                WADDR: begin
                    waddr_q <= awaddr;
                end
                WDATA: begin
                    if (wvalid) begin
                        bresp <= wr_in_range ? RESP_OKAY : RESP_DECERR;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory has no reset; contents survive a mid-transaction reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[wr_idx] <= wdata;
        end
    end
endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Randomized self-checking bench for axi_lite_mem_responder against an array-based memory model.
// Follows AXI_LITE_ADDR_CHECK_EN the same way the design does.
module tb_axi_lite_mem_responder;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;
    localparam int DEPTH = 4096;
`ifdef AXI_LITE_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [7:0]  rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [7:0]  wdata = '0;
    logic [0:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_mem   [DEPTH];
    bit         model_known [DEPTH];

    axi_lite_mem_responder dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return !ADDR_CHECK || (a[31:12] == 20'h0);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_arready"}, arready, 0);
        check({tag, "_rvalid"},  rvalid,  0);
        check({tag, "_awready"}, awready, 0);
        check({tag, "_wready"},  wready,  0);
        check({tag, "_bvalid"},  bvalid,  0);
    endtask

    // Caller is one timestep after a rising edge with the responder idle.
    task automatic do_write(input logic [31:0] a, input logic [7:0] d, input logic s,
                            input int wdelay, input int bstall);
        int cnt;
        logic [1:0] exp_resp;
        exp_resp = addr_ok(a) ? OKAY : DECERR;
        awaddr = a;
        awvalid = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk); #1; cnt++;
        end while (!awready && cnt < 20);
        check("aw_latency", cnt, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("awready_one_cycle", awready, 0);
        check("wready", wready, 1);
        for (int i = 0; i < wdelay; i++) begin
            @(posedge clk); #1;
            check("wready_hold", wready, 1);
            check("bvalid_early", bvalid, 0);
        end
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        bready = (bstall == 0);
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("bvalid", bvalid, 1);
        check("bresp", bresp, exp_resp);
        if (addr_ok(a) && s) begin
            model_mem[a[11:0]]   = d;
            model_known[a[11:0]] = 1'b1;
        end
        for (int i = 0; i < bstall; i++) begin
            @(posedge clk); #1;
            check("bvalid_stall", bvalid, 1);
            check("bresp_stall", bresp, exp_resp);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        check("bvalid_clear", bvalid, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input int stall);
        int cnt;
        bit known;
        logic [7:0] exp_data;
        logic [1:0] exp_resp;
        if (addr_ok(a)) begin
            known = model_known[a[11:0]];
            exp_data = model_mem[a[11:0]];
            exp_resp = OKAY;
        end else begin
            known = 1'b1;
            exp_data = 8'h00;
            exp_resp = DECERR;
        end
        rready = (stall == 0);
        araddr = a;
        arvalid = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk); #1; cnt++;
        end while (!arready && cnt < 20);
        check("ar_latency", cnt, 1);
        check("awready_during_read", awready, 0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid", rvalid, 1);
        check("rresp", rresp, exp_resp);
        if (known) check("rdata", rdata, exp_data);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("rvalid_stall", rvalid, 1);
            check("arready_stall", arready, 0);
            check("rresp_stall", rresp, exp_resp);
            if (known) check("rdata_stall", rdata, exp_data);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        check("rvalid_clear", rvalid, 0);
    endtask

    initial begin
        int cnt;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

        #12;
        check_idle_outputs("reset");
        check("reset_rdata", rdata, 0);
        check("reset_rresp", rresp, OKAY);
        check("reset_bresp", bresp, OKAY);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        // basic write then read
        do_write(32'h4, 8'hA5, 1'b1, 0, 0);
        do_read(32'h4, 0);

        // zero strobe leaves memory untouched
        do_write(32'h14, 8'h3C, 1'b1, 1, 0);
        do_write(32'h14, 8'hFF, 1'b0, 0, 0);
        do_read(32'h14, 0);

        // simultaneous read and write: read goes first
        awaddr = 32'h14;
        awvalid = 1'b1;
        do_read(32'h4, 0);
        do_write(32'h14, 8'h77, 1'b1, 0, 0);
        do_read(32'h14, 0);

        // read stalled by the master
        do_read(32'h4, 5);
        check_idle_outputs("after_stall");

        // address above the memory range
        do_write(32'h1004, 8'h11, 1'b1, 0, 2);
        do_read(32'h1004, 0);
        do_read(32'h4, 0);

        // reset while waiting for write data
        awaddr = 32'h4;
        awvalid = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk); #1; cnt++;
        end while (!awready && cnt < 20);
        check("rst_aw_latency", cnt, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("rst_wready_before", wready, 1);
        wdata = 8'hEE;
        wstrb = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        check("mid_reset_rdata", rdata, 0);
        check("mid_reset_bresp", bresp, OKAY);
        check("mid_reset_rresp", rresp, OKAY);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_mid_reset");
        do_read(32'h4, 0);
        do_write(32'h8, 8'h5A, 1'b1, 0, 0);
        do_read(32'h8, 0);

        // randomized mix
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0)
                do_write(a, 8'($urandom), ($urandom_range(0, 3) != 0),
                         $urandom_range(0, 2), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
